// File: rtl/pea_output_stage.sv
// Buffers core result/status pairs and writes each pair into both output FIFOs together.
// Latency: a pair pushed at edge N is popped at edge N+1, and both FIFO writes happen in the cycle after N+1.
// Backpressure: a pair is only popped when both FIFOs have space; a push into a full buffer with no pop that cycle is dropped and overflow is set.
module pea_output_stage #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024,
    parameter int pair_depth  = 8,
    parameter int reserve     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_out,
    input  logic [2*word_size-1:0]           data_out_result,
    input  logic [2*word_size-1:0]           data_out_status,
    input  logic                             FC,
    input  logic [$clog2(buffer_size)-1:0]   result_free_space,
    input  logic [$clog2(buffer_size)-1:0]   status_free_space,
    output logic                             result_wr_en,
    output logic [2*word_size-1:0]           result_out,
    output logic                             status_wr_en,
    output logic [2*word_size-1:0]           status_out,
    output logic                             can_invoke,
    output logic [$clog2(pair_depth):0]      pair_count,
    output logic                             overflow,
    output logic [15:0]                      firing_count
);

    localparam int TW = 2 * word_size;
    localparam int PW = $clog2(pair_depth);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TW-1:0] result;
        logic [TW-1:0] status;
    } pair_t;

    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_t;

    drain_state_t  state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] result_out_q, result_out_d;
    logic [TW-1:0] status_out_q, status_out_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   firing_count_q, firing_count_d;
    pair_t         mem_q [pair_depth];
    pair_t         mem_d [pair_depth];

    logic          full;
    logic          space_ok;
    logic          pop;
    logic          push;
    logic [CW-1:0] free_entries;

    // Push/pop decisions: a pop frees the slot a same-cycle push into a full buffer needs.
    always_comb begin
        full     = (count_q == CW'(pair_depth));
        space_ok = (result_free_space != '0) && (status_free_space != '0);
        pop      = (state_q == DRAIN_IDLE) && (count_q != '0) && space_ok;
        push     = wr_out && (!full || pop);
    end

    // Next-state for the drain FSM, pointers, occupancy, output registers and counters.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        result_out_d   = result_out_q;
        status_out_d   = status_out_q;
        overflow_d     = overflow_q;
        firing_count_d = firing_count_q;

        unique case (state_q)
            DRAIN_IDLE: begin
                if (pop) begin
                    result_out_d = mem_q[rd_ptr_q].result;
                    status_out_d = mem_q[rd_ptr_q].status;
                    rd_ptr_d     = rd_ptr_q + PW'(1);
                    state_d      = DRAIN_WRITE;
                end
            end
            // Always return to idle so fresh free-space values are seen before the next pop.
            DRAIN_WRITE: state_d = DRAIN_IDLE;
            default:     state_d = DRAIN_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (wr_out) begin
            overflow_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (FC) begin
            firing_count_d = firing_count_q + 16'd1;
        end
    end

    // Pair storage next-value: only the slot at the write pointer changes on a push.
    always_comb begin
        for (int i = 0; i < pair_depth; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{result: data_out_result, status: data_out_status};
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= DRAIN_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            result_out_q   <= '0;
            status_out_q   <= '0;
            overflow_q     <= 1'b0;
            firing_count_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            result_out_q   <= result_out_d;
            status_out_q   <= status_out_d;
            overflow_q     <= overflow_d;
            firing_count_q <= firing_count_d;
        end
    end

    // Pair storage is not reset: occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < pair_depth; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Headroom report for the invoke scheduler, combinational from registered occupancy.
    always_comb begin
        free_entries = CW'(pair_depth) - count_q;
        can_invoke   = (free_entries >= CW'(reserve));
    end

    assign result_wr_en = (state_q == DRAIN_WRITE);
    assign status_wr_en = (state_q == DRAIN_WRITE);
    assign result_out   = result_out_q;
    assign status_out   = status_out_q;
    assign pair_count   = count_q;
    assign overflow     = overflow_q;
    assign firing_count = firing_count_q;

endmodule

// File: tb/tb_pea_output_stage.sv
// Bench for pea_output_stage: randomized and directed stimulus against a queue-based reference model.
// The model predicts every FIFO write; a negedge monitor pops and compares each observed write.
// Per-cycle checks cover occupancy, headroom, overflow, firing count and output hold.
module tb_pea_output_stage;

    localparam int DEPTH = 8;
    localparam int RSV   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_out;
    logic [31:0] data_out_result;
    logic [31:0] data_out_status;
    logic        FC;
    logic [9:0]  result_free_space;
    logic [9:0]  status_free_space;
    logic        result_wr_en;
    logic [31:0] result_out;
    logic        status_wr_en;
    logic [31:0] status_out;
    logic        can_invoke;
    logic [3:0]  pair_count;
    logic        overflow;
    logic [15:0] firing_count;

    pea_output_stage #(
        .word_size(16), .buffer_size(1024), .pair_depth(DEPTH), .reserve(RSV)
    ) dut (
        .clk(clk), .rst(rst), .wr_out(wr_out),
        .data_out_result(data_out_result), .data_out_status(data_out_status),
        .FC(FC), .result_free_space(result_free_space), .status_free_space(status_free_space),
        .result_wr_en(result_wr_en), .result_out(result_out),
        .status_wr_en(status_wr_en), .status_out(status_out),
        .can_invoke(can_invoke), .pair_count(pair_count),
        .overflow(overflow), .firing_count(firing_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [63:0] mq[$];      // pairs held in the buffer, oldest first
    logic [63:0] exp_q[$];   // pairs expected on the FIFO write ports
    bit          m_busy;     // a write cycle follows the last pop
    bit          m_ovf;
    logic [15:0] m_fc;
    logic [31:0] m_res, m_sts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated on the same edge the DUT samples its inputs.
    always @(posedge clk) begin : model
        bit          pop_now;
        logic [63:0] p;
        if (rst !== 1'b1) begin
            mq.delete();
            exp_q.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_fc   = '0;
            m_res  = '0;
            m_sts  = '0;
        end else begin
            pop_now = !m_busy && (mq.size() > 0) && (result_free_space >= 1) && (status_free_space >= 1);
            if (pop_now) begin
                p = mq.pop_front();
                exp_q.push_back(p);
                m_res = p[63:32];
                m_sts = p[31:0];
            end
            if (wr_out) begin
                if (mq.size() < DEPTH) mq.push_back({data_out_result, data_out_status});
                else m_ovf = 1'b1;
            end
            m_busy = pop_now;
            m_fc   = m_fc + 16'(FC);
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (mon_en) begin
            chk("result_wr_en", 32'(result_wr_en), 32'(m_busy));
            chk("status_wr_en", 32'(status_wr_en), 32'(m_busy));
            if (result_wr_en === 1'b1) begin
                n_wr++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got %h/%h expected no write", result_out, status_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_result", result_out, e[63:32]);
                    chk("write_status", status_out, e[31:0]);
                end
            end
            chk("result_out_hold", result_out, m_res);
            chk("status_out_hold", status_out, m_sts);
            chk("pair_count", 32'(pair_count), 32'(mq.size()));
            chk("can_invoke", 32'(can_invoke), 32'((DEPTH - mq.size()) >= RSV));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("firing_count", 32'(firing_count), 32'(m_fc));
        end
    end

    task automatic push(input logic [31:0] r, input logic [31:0] s);
        wr_out = 1'b1;
        data_out_result = r;
        data_out_status = s;
        @(negedge clk);
        wr_out = 1'b0;
    endtask

    task automatic set_space(input int r, input int s);
        result_free_space = 10'(r);
        status_free_space = 10'(s);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_out = 1'b0;
        FC = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : stim
        int  w0;
        bit  seen;
        rst = 1'b0; wr_out = 1'b0; FC = 1'b0;
        data_out_result = '0; data_out_status = '0;
        set_space(0, 0);

        // Reset values
        do_reset();
        mon_en = 1'b1;
        chk("rst_wr_en", 32'(result_wr_en | status_wr_en), 32'd0);
        chk("rst_pair_count", 32'(pair_count), 32'd0);
        chk("rst_can_invoke", 32'(can_invoke), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_firing_count", 32'(firing_count), 32'd0);

        // Single pair: write appears two edges after the pulse
        set_space(100, 100);
        push(32'h0000_0123, 32'h0000_0001);
        chk("single_no_early_write", 32'(result_wr_en), 32'd0);
        @(negedge clk);
        chk("single_write_en", 32'(result_wr_en & status_wr_en), 32'd1);
        chk("single_result", result_out, 32'h0000_0123);
        chk("single_status", status_out, 32'h0000_0001);
        @(negedge clk);
        chk("single_wr_en_low", 32'(result_wr_en), 32'd0);
        chk("single_pair_count", 32'(pair_count), 32'd0);

        // Back-pressure: status FIFO full blocks the whole pair
        set_space(50, 0);
        w0 = n_wr;
        for (int i = 0; i < 3; i++) push(32'hA000_0000 + i, 32'hB000_0000 + i);
        repeat (3) @(negedge clk);
        chk("bp_no_writes", 32'(n_wr - w0), 32'd0);
        chk("bp_pair_count", 32'(pair_count), 32'd3);
        set_space(50, 50);
        repeat (10) @(negedge clk);
        chk("bp_released_writes", 32'(n_wr - w0), 32'd3);

        // Full buffer with a push in the exact cycle of the pop
        set_space(0, 0);
        for (int i = 0; i < DEPTH; i++) push(32'hC000_0000 + i, 32'hD000_0000 + i);
        chk("full_pair_count", 32'(pair_count), 32'd8);
        set_space(100, 100);
        push(32'hC000_00FF, 32'hD000_00FF);
        chk("fullpop_pair_count", 32'(pair_count), 32'd8);
        chk("fullpop_overflow", 32'(overflow), 32'd0);
        repeat (25) @(negedge clk);
        chk("fullpop_drained", 32'(pair_count), 32'd0);

        // Fill and overflow: only the first 8 of 10 pairs survive
        set_space(0, 0);
        w0 = n_wr;
        for (int i = 0; i < 10; i++) push(32'hE000_0000 + i, 32'hF000_0000 + i);
        chk("fill_pair_count", 32'(pair_count), 32'd8);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_can_invoke", 32'(can_invoke), 32'd0);
        set_space(100, 100);
        repeat (25) @(negedge clk);
        chk("fill_emitted", 32'(n_wr - w0), 32'd8);
        chk("fill_overflow_sticky", 32'(overflow), 32'd1);

        // Randomized traffic with throttled free space and firing pulses
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            wr_out = 1'($urandom_range(0, 1));
            data_out_result = $urandom;
            data_out_status = $urandom;
            FC = 1'($urandom_range(0, 1));
            set_space($urandom_range(0, 2), $urandom_range(0, 2));
            @(negedge clk);
        end
        wr_out = 1'b0; FC = 1'b0;
        set_space(100, 100);
        repeat (25) @(negedge clk);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        // Firing count wrap
        do_reset();
        FC = 1'b1;
        repeat (65535) @(negedge clk);
        FC = 1'b0;
        chk("fc_preload", 32'(firing_count), 32'h0000_FFFF);
        FC = 1'b1;
        @(negedge clk);
        FC = 1'b0;
        chk("fc_wrap", 32'(firing_count), 32'd0);

        // Reset while a write is in flight
        push(32'h1234_5678, 32'h9ABC_DEF0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (result_wr_en === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("midwrite_reached", 32'(seen), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midwrite_wr_en", 32'(result_wr_en | status_wr_en), 32'd0);
        chk("midwrite_pair_count", 32'(pair_count), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
